// File: rtl/apbmaster_if.sv
// apbmaster_if: bundles the apbmaster command, response and APB completer signals.
//   Command : i_valid, o_ready, i_addr, i_write, i_wdata, i_wstrb, i_prot
//   Response: o_rvalid, i_rready, o_rdata, o_err
//   APB     : PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT, PREADY, PRDATA, PSLVERR
// Signal names are written from the bridge's point of view (i_ = into the bridge).
// Modport master is the bridge itself; modport slave is everything around it
// (initiator on the command/response side plus the APB completer).
interface apbmaster_if #(
   parameter int unsigned C_APB_ADDR_WIDTH = 12,
   parameter int unsigned C_APB_DATA_WIDTH = 32
);
   localparam int unsigned AW = C_APB_ADDR_WIDTH;
   localparam int unsigned DW = C_APB_DATA_WIDTH;
   localparam int unsigned SW = C_APB_DATA_WIDTH / 8;

   // command port
   logic          i_valid;
   logic          o_ready;
   logic [AW-1:0] i_addr;
   logic          i_write;
   logic [DW-1:0] i_wdata;
   logic [SW-1:0] i_wstrb;
   logic [2:0]    i_prot;
   // response port
   logic          o_rvalid;
   logic          i_rready;
   logic [DW-1:0] o_rdata;
   logic          o_err;
   // APB requester side
   logic          PSEL;
   logic          PENABLE;
   logic [AW-1:0] PADDR;
   logic          PWRITE;
   logic [DW-1:0] PWDATA;
   logic [SW-1:0] PWSTRB;
   logic [2:0]    PPROT;
   logic          PREADY;
   logic [DW-1:0] PRDATA;
   logic          PSLVERR;

   modport master (
      input  i_valid, i_addr, i_write, i_wdata, i_wstrb, i_prot, i_rready,
      input  PREADY, PRDATA, PSLVERR,
      output o_ready, o_rvalid, o_rdata, o_err,
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT
   );

   modport slave (
      output i_valid, i_addr, i_write, i_wdata, i_wstrb, i_prot, i_rready,
      output PREADY, PRDATA, PSLVERR,
      input  o_ready, o_rvalid, o_rdata, o_err,
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PWSTRB, PPROT
   );
endinterface

// File: rtl/apbmaster.sv
// apbmaster: APB4 requester bridge. Takes one single-beat command at a time on a
// valid/ready port, runs it as an APB SETUP/ACCESS transfer and returns read data
// plus error status on a valid/ready response port. A wait-state counter aborts
// transfers whose completer keeps PREADY low for C_TIMEOUT ACCESS cycles
// (C_TIMEOUT = 0 disables the abort).
// Ports:
//   PCLK    - clock
//   PRESETn - asynchronous active-low reset
//   bus     - apbmaster_if.master: command, response and APB signals
module apbmaster #(
   parameter int unsigned C_APB_ADDR_WIDTH = 12,
   parameter int unsigned C_APB_DATA_WIDTH = 32,
   parameter int unsigned C_TIMEOUT        = 16
) (
   input logic         PCLK,
   input logic         PRESETn,
   apbmaster_if.master bus
);
   localparam int unsigned AW   = C_APB_ADDR_WIDTH;
   localparam int unsigned DW   = C_APB_DATA_WIDTH;
   localparam int unsigned SW   = C_APB_DATA_WIDTH / 8;
   localparam int unsigned CntW = (C_TIMEOUT == 0) ? 1 : $clog2(C_TIMEOUT + 1);
   // Counter value seen in the last permitted wait cycle; unused when C_TIMEOUT == 0.
   localparam logic [CntW-1:0] CntLast = CntW'(C_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e          state_q, state_d;
   logic            psel_q, psel_d;
   logic            penable_q, penable_d;
   logic [AW-1:0]   paddr_q, paddr_d;
   logic            pwrite_q, pwrite_d;
   logic [DW-1:0]   pwdata_q, pwdata_d;
   logic [SW-1:0]   pwstrb_q, pwstrb_d;
   logic [2:0]      pprot_q, pprot_d;
   logic            rvalid_q, rvalid_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= StIdle;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         pwstrb_q  <= '0;
         pprot_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         paddr_q   <= paddr_d;
         pwrite_q  <= pwrite_d;
         pwdata_q  <= pwdata_d;
         pwstrb_q  <= pwstrb_d;
         pprot_q   <= pprot_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      paddr_d   = paddr_q;
      pwrite_d  = pwrite_q;
      pwdata_d  = pwdata_q;
      pwstrb_d  = pwstrb_q;
      pprot_d   = pprot_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         StIdle: begin
            // o_ready is high in this state, so i_valid alone means acceptance.
            if (bus.i_valid) begin
               paddr_d   = bus.i_addr;
               pwrite_d  = bus.i_write;
               pwdata_d  = bus.i_wdata;
               pwstrb_d  = bus.i_write ? bus.i_wstrb : '0;
               pprot_d   = bus.i_prot;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               state_d   = StSetup;
            end
         end
         StSetup: begin
            penable_d = 1'b1;
            cnt_d     = '0;
            state_d   = StAccess;
         end
         StAccess: begin
            if (bus.PREADY) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               rdata_d   = pwrite_q ? '0 : bus.PRDATA;
               err_d     = bus.PSLVERR;
               rvalid_d  = 1'b1;
               state_d   = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
               if ((C_TIMEOUT != 0) && (cnt_q == CntLast)) begin
                  psel_d    = 1'b0;
                  penable_d = 1'b0;
                  rdata_d   = '0;
                  err_d     = 1'b1;
                  rvalid_d  = 1'b1;
                  state_d   = StResp;
               end
            end
         end
         StResp: begin
            // rdata/err are left untouched so they persist until the next response.
            if (bus.i_rready) begin
               rvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.o_ready  = (state_q == StIdle);
   assign bus.o_rvalid = rvalid_q;
   assign bus.o_rdata  = rdata_q;
   assign bus.o_err    = err_q;
   assign bus.PSEL     = psel_q;
   assign bus.PENABLE  = penable_q;
   assign bus.PADDR    = paddr_q;
   assign bus.PWRITE   = pwrite_q;
   assign bus.PWDATA   = pwdata_q;
   assign bus.PWSTRB   = pwstrb_q;
   assign bus.PPROT    = pprot_q;
endmodule

// File: tb/tb_apbmaster.sv
// tb_apbmaster: directed bench for apbmaster (AW=12, DW=32, C_TIMEOUT=4).
// A transaction-level model predicts every cycle of each command from its wait
// count and response delay; a compare process checks all outputs each cycle, and
// each transaction also checks hand-computed literal counts and response values.
module tb_apbmaster;
   localparam int unsigned AW  = 12;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = 4;
   localparam int          TMO = 4;

   logic PCLK    = 1'b0;
   logic PRESETn = 1'b1;

   apbmaster_if #(.C_APB_ADDR_WIDTH(AW), .C_APB_DATA_WIDTH(DW)) bus ();

   apbmaster #(
      .C_APB_ADDR_WIDTH(AW),
      .C_APB_DATA_WIDTH(DW),
      .C_TIMEOUT(TMO)
   ) dut (
      .PCLK(PCLK),
      .PRESETn(PRESETn),
      .bus(bus)
   );

   always #5 PCLK = ~PCLK;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // ACCESS cycles a command occupies given the completer's wait count.
   function automatic int calc_n(input int waits);
      return (waits >= TMO) ? TMO : waits + 1;
   endfunction

   // command mailbox written by the driver at acceptance
   int            c_seq    = 0;
   int            c_t0     = 0;
   logic [AW-1:0] c_addr   = '0;
   logic          c_write  = 1'b0;
   logic [DW-1:0] c_wdata  = '0;
   logic [SW-1:0] c_wstrb  = '0;
   logic [2:0]    c_prot   = '0;
   int            c_waits  = 0;
   logic [DW-1:0] c_prdata = '0;
   logic          c_slverr = 1'b0;
   int            c_d      = 0;

   // model state, owned by the compare process
   int            m_seq    = 0;
   bit            m_active = 1'b0;
   int            m_t0     = 0;
   int            m_n      = 0;
   int            m_d      = 0;
   int            rel      = 0;
   logic [AW-1:0] m_addr   = '0;
   logic          m_write  = 1'b0;
   logic [DW-1:0] m_wdata  = '0;
   logic [SW-1:0] m_wstrb  = '0;
   logic [2:0]    m_prot   = '0;
   logic [DW-1:0] m_rdata  = '0;
   logic          m_err    = 1'b0;
   logic [DW-1:0] p_rdata  = '0;
   logic          p_err    = 1'b0;
   logic          e_ready, e_psel, e_pen, e_rv;
   bit            to;

   always @(posedge PCLK) begin
      #1;
      if (!PRESETn) begin
         m_seq    = c_seq;
         m_active = 1'b0;
         m_addr   = '0;
         m_write  = 1'b0;
         m_wdata  = '0;
         m_wstrb  = '0;
         m_prot   = '0;
         m_rdata  = '0;
         m_err    = 1'b0;
      end else begin
         if (c_seq != m_seq) begin
            m_seq    = c_seq;
            m_active = 1'b1;
            m_t0     = c_t0;
            m_n      = calc_n(c_waits);
            m_d      = c_d;
            m_addr   = c_addr;
            m_write  = c_write;
            m_wdata  = c_wdata;
            m_wstrb  = c_write ? c_wstrb : '0;
            m_prot   = c_prot;
            to       = (c_waits >= TMO);
            p_rdata  = (to || c_write) ? '0 : c_prdata;
            p_err    = to ? 1'b1 : c_slverr;
         end
         e_ready = 1'b1;
         e_psel  = 1'b0;
         e_pen   = 1'b0;
         e_rv    = 1'b0;
         if (m_active) begin
            rel = cyc - m_t0;
            if (rel == 1) begin
               e_ready = 1'b0;
               e_psel  = 1'b1;
            end else if (rel <= 1 + m_n) begin
               e_ready = 1'b0;
               e_psel  = 1'b1;
               e_pen   = 1'b1;
            end else if (rel <= 2 + m_n + m_d) begin
               e_ready = 1'b0;
               e_rv    = 1'b1;
               if (rel == 2 + m_n) begin
                  m_rdata = p_rdata;
                  m_err   = p_err;
               end
            end else begin
               m_active = 1'b0;
            end
         end
         chk("o_ready", 32'(bus.o_ready), 32'(e_ready));
         chk("PSEL", 32'(bus.PSEL), 32'(e_psel));
         chk("PENABLE", 32'(bus.PENABLE), 32'(e_pen));
         chk("o_rvalid", 32'(bus.o_rvalid), 32'(e_rv));
         chk("PADDR", 32'(bus.PADDR), 32'(m_addr));
         chk("PWRITE", 32'(bus.PWRITE), 32'(m_write));
         chk("PWDATA", bus.PWDATA, m_wdata);
         chk("PWSTRB", 32'(bus.PWSTRB), 32'(m_wstrb));
         chk("PPROT", 32'(bus.PPROT), 32'(m_prot));
         chk("o_rdata", bus.o_rdata, m_rdata);
         chk("o_err", 32'(bus.o_err), 32'(m_err));
      end
   end

   // Runs one command from a negedge-aligned start. waits = PREADY-low ACCESS cycles
   // before ready (>= TMO means never ready), d = cycles i_rready stays low.
   // abort_at > 0 pulses PRESETn in that cycle instead of completing.
   task automatic run_txn(
      input logic [AW-1:0] addr, input logic write, input logic [DW-1:0] wdata,
      input logic [SW-1:0] wstrb, input logic [2:0] prot, input int waits,
      input logic [DW-1:0] prdata, input logic slverr, input int d, input int abort_at,
      input int e_psel_c, input int e_pen_c, input int e_first, input int e_rvc,
      input logic [DW-1:0] e_rdata, input logic e_err);
      int n, last, psel_c, pen_c, rv_c, first_rv;
      logic [DW-1:0] got_rdata;
      logic got_err;
      n = calc_n(waits);
      last = 2 + n + d;
      psel_c = 0; pen_c = 0; rv_c = 0; first_rv = 0;
      got_rdata = '0; got_err = 1'b0;
      c_addr = addr; c_write = write; c_wdata = wdata; c_wstrb = wstrb; c_prot = prot;
      c_waits = waits; c_prdata = prdata; c_slverr = slverr; c_d = d;
      c_t0 = cyc;
      c_seq = c_seq + 1;
      bus.i_valid = 1'b1; bus.i_addr = addr; bus.i_write = write; bus.i_wdata = wdata;
      bus.i_wstrb = wstrb; bus.i_prot = prot; bus.i_rready = 1'b0;
      bus.PREADY = 1'b1; bus.PRDATA = 32'hFEED_0000; bus.PSLVERR = 1'b1;
      for (int r = 1; r <= last; r++) begin
         @(negedge PCLK);
         psel_c += int'(bus.PSEL);
         pen_c  += int'(bus.PENABLE);
         rv_c   += int'(bus.o_rvalid);
         if (bus.o_rvalid && first_rv == 0) first_rv = r;
         if (r == last) begin
            got_rdata = bus.o_rdata;
            got_err   = bus.o_err;
         end
         // a competing command that must be ignored while busy
         bus.i_valid = 1'b1; bus.i_addr = ~addr; bus.i_write = ~write; bus.i_wdata = ~wdata;
         bus.i_wstrb = ~wstrb; bus.i_prot = ~prot;
         bus.i_rready = (r == last);
         if (r >= 2 && r <= 1 + n && r == 2 + waits) begin
            bus.PREADY = 1'b1; bus.PRDATA = prdata; bus.PSLVERR = slverr;
         end else if (r >= 2 && r <= 1 + n) begin
            bus.PREADY = 1'b0; bus.PRDATA = 32'hBAD0_0000 | r; bus.PSLVERR = 1'b1;
         end else begin
            bus.PREADY = 1'b1; bus.PRDATA = 32'hBEEF_0000 | r; bus.PSLVERR = 1'b1;
         end
         if (r == abort_at) begin
            #2 PRESETn = 1'b0;
            #1;
            chk("rst_psel", 32'(bus.PSEL), 32'd0);
            chk("rst_penable", 32'(bus.PENABLE), 32'd0);
            chk("rst_rvalid", 32'(bus.o_rvalid), 32'd0);
            chk("rst_ready", 32'(bus.o_ready), 32'd1);
            @(negedge PCLK);
            PRESETn = 1'b1;
            bus.i_valid = 1'b0; bus.i_rready = 1'b0; bus.PREADY = 1'b0;
            @(negedge PCLK);
            return;
         end
      end
      @(negedge PCLK);
      bus.i_valid = 1'b0; bus.i_rready = 1'b0; bus.PREADY = 1'b0;
      chk("lit_psel_cycles", 32'(psel_c), 32'(e_psel_c));
      chk("lit_penable_cycles", 32'(pen_c), 32'(e_pen_c));
      chk("lit_first_rvalid", 32'(first_rv), 32'(e_first));
      chk("lit_rvalid_cycles", 32'(rv_c), 32'(e_rvc));
      chk("lit_rdata", got_rdata, e_rdata);
      chk("lit_err", 32'(got_err), 32'(e_err));
   endtask

   initial begin
      bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_write = 1'b0; bus.i_wdata = '0;
      bus.i_wstrb = '0; bus.i_prot = '0; bus.i_rready = 1'b0;
      bus.PREADY = 1'b0; bus.PRDATA = '0; bus.PSLVERR = 1'b0;
      #1 PRESETn = 1'b0;
      #2;
      chk("reset_psel", 32'(bus.PSEL), 32'd0);
      chk("reset_penable", 32'(bus.PENABLE), 32'd0);
      chk("reset_rvalid", 32'(bus.o_rvalid), 32'd0);
      chk("reset_err", 32'(bus.o_err), 32'd0);
      chk("reset_ready", 32'(bus.o_ready), 32'd1);
      chk("reset_paddr", 32'(bus.PADDR), 32'd0);
      chk("reset_pwstrb", 32'(bus.PWSTRB), 32'd0);
      chk("reset_rdata", bus.o_rdata, 32'd0);
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK);

      // write, zero-wait
      run_txn(12'h010, 1'b1, 32'hDEADBEEF, 4'hF, 3'd0, 0, 32'h0, 1'b0, 0, 0,
              2, 1, 3, 1, 32'h0, 1'b0);
      // read, 3 wait states
      run_txn(12'h124, 1'b0, 32'h0, 4'hF, 3'b010, 3, 32'h12345678, 1'b0, 0, 0,
              5, 4, 6, 1, 32'h12345678, 1'b0);
      // read with PSLVERR, unaligned address
      run_txn(12'h203, 1'b0, 32'h0, 4'h3, 3'b001, 0, 32'hA5A50F0F, 1'b1, 0, 0,
              2, 1, 3, 1, 32'hA5A50F0F, 1'b1);
      // following write accepted normally, partial strobes
      run_txn(12'h3FC, 1'b1, 32'h00C0FFEE, 4'h6, 3'b111, 1, 32'h0, 1'b0, 0, 0,
              3, 2, 4, 1, 32'h0, 1'b0);
      // read timeout, PREADY never high
      run_txn(12'h044, 1'b0, 32'h0, 4'hF, 3'd0, 99, 32'h11111111, 1'b0, 0, 0,
              5, 4, 6, 1, 32'h0, 1'b1);
      // ready exactly in the 4th ACCESS cycle: normal completion
      run_txn(12'h048, 1'b0, 32'h0, 4'hF, 3'd0, 3, 32'h0BADCAFE, 1'b0, 0, 0,
              5, 4, 6, 1, 32'h0BADCAFE, 1'b0);
      // write whose ready would come one cycle too late: timeout
      run_txn(12'h04C, 1'b1, 32'h87654321, 4'h9, 3'b100, 4, 32'h0, 1'b0, 0, 0,
              5, 4, 6, 1, 32'h0, 1'b1);
      // response backpressure, i_rready low 5 cycles
      run_txn(12'h0A0, 1'b0, 32'h0, 4'hF, 3'd0, 0, 32'h5555AAAA, 1'b0, 5, 0,
              2, 1, 3, 6, 32'h5555AAAA, 1'b0);
      // reset during ACCESS
      run_txn(12'h0B0, 1'b0, 32'h0, 4'hF, 3'b011, 99, 32'h0, 1'b0, 0, 3,
              0, 0, 0, 0, 32'h0, 1'b0);
      // fresh read after reset
      run_txn(12'h0C4, 1'b0, 32'h0, 4'hF, 3'b000, 1, 32'hCAFEF00D, 1'b0, 0, 0,
              3, 2, 4, 1, 32'hCAFEF00D, 1'b0);

      repeat (2) @(negedge PCLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
